// File: rtl/frame_playout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frame_playout_ctrl
// Description : Drains the 192-bit datapath FIFO once it reaches a start
//               level. Each word released on the paced read strobe is
//               presented as NUM_CH parallel channel samples with a one-cycle
//               valid pulse. Missed frames (underrun) are detected, counted,
//               and the FIFO is re-primed before playout resumes.
//               Optional feature macro: PLAYOUT_ZERO_ON_UNDERRUN_EN
//               (emit a zeroed sample on each underrun).
// Revision    : 1.0 - initial release
// ============================================================================
module frame_playout_ctrl #(
  parameter int DATA_WIDTH    = 192,
  parameter int NUM_CH        = 8,
  parameter int CH_WIDTH      = 24,
  parameter int DEPTH_SIZE    = 10,
  parameter int START_LEVEL   = 512,
  parameter int FRAME_PERIOD  = 30,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic                     clr_status,
  input  logic [DEPTH_SIZE-1:0]    fifo_data_count,
  input  logic                     fifo_rd_en_100ns,
  input  logic [DATA_WIDTH-1:0]    fifo_data_out,
  output logic                     fifo_rd,
  output logic [DATA_WIDTH-1:0]    ch_data,
  output logic                     ch_valid,
  output logic [1:0]               state,
  output logic [ERR_CNT_WIDTH-1:0] underrun_cnt,
  output logic                     underrun_flag,
  output logic [31:0]              frame_cnt
);

  localparam int                    WD_WIDTH  = $clog2(FRAME_PERIOD + 1);
  localparam logic [WD_WIDTH-1:0]   WD_LIMIT  = WD_WIDTH'(FRAME_PERIOD);
  localparam logic [DEPTH_SIZE-1:0] START_LVL = DEPTH_SIZE'(START_LEVEL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } state_t;

  state_t              cur_state;
  state_t              nxt_state;
  logic [WD_WIDTH-1:0] wd_cnt;
  logic                pending;
  logic                level_ok;
  logic                underrun;

  // The channel slicing only makes sense when the word is an exact multiple
  generate
    if (NUM_CH * CH_WIDTH != DATA_WIDTH) begin : g_bad_width
      $error("frame_playout_ctrl: NUM_CH*CH_WIDTH must equal DATA_WIDTH");
    end
  endgenerate

  assign level_ok = (fifo_data_count >= START_LVL);
  // A strobe arriving on the limit cycle still counts as a delivered frame
  assign underrun = (cur_state == RUN) && enable && !fifo_rd_en_100ns &&
                    (wd_cnt == WD_LIMIT);
  assign state    = cur_state;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; enable=0 always has priority
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:    if (enable) nxt_state = PRIME;
      PRIME:   if (!enable) nxt_state = IDLE;
               else if (level_ok) nxt_state = RUN;
      RUN:     if (!enable) nxt_state = IDLE;
               else if (underrun) nxt_state = STALL;
      STALL:   if (!enable) nxt_state = IDLE;
               else if (level_ok) nxt_state = RUN;
      default: nxt_state = IDLE;
    endcase
  end

  // Read request tracks the state register exactly, so it is driven from next-state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) fifo_rd <= 1'b0;
    else       fifo_rd <= (nxt_state == RUN);
  end

  // Watchdog: counts strobe-free cycles while staying in RUN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      wd_cnt <= '0;
    else if ((cur_state != RUN) || (nxt_state != RUN) || fifo_rd_en_100ns)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end

  // Capture: FIFO output is valid the cycle after its strobe, in any state
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending   <= 1'b0;
      ch_data   <= '0;
      ch_valid  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      pending  <= fifo_rd_en_100ns;
      ch_valid <= 1'b0;
      if (pending) begin
        ch_data   <= fifo_data_out;
        ch_valid  <= 1'b1;
        frame_cnt <= frame_cnt + 32'd1;
      end
`ifdef PLAYOUT_ZERO_ON_UNDERRUN_EN
      else if (underrun) begin
        ch_data  <= '0;
        ch_valid <= 1'b1;
      end
`endif
    end
  end

  // Underrun status: an event in the same cycle as a clear wins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      underrun_cnt  <= '0;
      underrun_flag <= 1'b0;
    end else if (underrun) begin
      underrun_flag <= 1'b1;
      if (clr_status)
        underrun_cnt <= ERR_CNT_WIDTH'(1);
      else if (!(&underrun_cnt))
        underrun_cnt <= underrun_cnt + 1'b1;
    end else if (clr_status) begin
      underrun_cnt  <= '0;
      underrun_flag <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_playout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_playout_ctrl
// Description : Directed self-checking bench for frame_playout_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frame_playout_ctrl;

  logic         clk;
  logic         rstn;
  logic         enable;
  logic         clr_status;
  logic [9:0]   fifo_data_count;
  logic         fifo_rd_en_100ns;
  logic [191:0] fifo_data_out;
  logic         fifo_rd;
  logic [191:0] ch_data;
  logic         ch_valid;
  logic [1:0]   state;
  logic [15:0]  underrun_cnt;
  logic         underrun_flag;
  logic [31:0]  frame_cnt;

  int total  = 0;
  int passed = 0;

  frame_playout_ctrl dut (
    .clk              (clk),
    .rstn             (rstn),
    .enable           (enable),
    .clr_status       (clr_status),
    .fifo_data_count  (fifo_data_count),
    .fifo_rd_en_100ns (fifo_rd_en_100ns),
    .fifo_data_out    (fifo_data_out),
    .fifo_rd          (fifo_rd),
    .ch_data          (ch_data),
    .ch_valid         (ch_valid),
    .state            (state),
    .underrun_cnt     (underrun_cnt),
    .underrun_flag    (underrun_flag),
    .frame_cnt        (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One strobe; the word appears on the FIFO output the following cycle
  task automatic strobe_word(input logic [191:0] w);
    fifo_rd_en_100ns = 1'b1;
    tick();
    fifo_rd_en_100ns = 1'b0;
    fifo_data_out    = w;
    check("valid_early", 192'(ch_valid), 192'(0));
    tick();
    check("valid_pulse", 192'(ch_valid), 192'(1));
    check("ch_data", ch_data, w);
  endtask

  logic [191:0] ch7_word;
  logic [191:0] held;

  initial begin
    rstn = 1'b0; enable = 1'b0; clr_status = 1'b0;
    fifo_data_count = '0; fifo_rd_en_100ns = 1'b0; fifo_data_out = '0;
    ch7_word = {24'hABCDEF, 168'd0};

    // Reset state
    repeat (3) tick();
    check("rst_state", 192'(state), 192'(0));
    check("rst_fifo_rd", 192'(fifo_rd), 192'(0));
    check("rst_ch_valid", 192'(ch_valid), 192'(0));
    check("rst_ch_data", ch_data, 192'(0));
    check("rst_ucnt", 192'(underrun_cnt), 192'(0));
    check("rst_uflag", 192'(underrun_flag), 192'(0));
    check("rst_frame_cnt", 192'(frame_cnt), 192'(0));
    rstn = 1'b1;
    tick();
    check("idle_hold", 192'(state), 192'(0));

    // Priming below and at the start level
    enable = 1'b1; fifo_data_count = 10'd511;
    tick();
    check("prime_state", 192'(state), 192'(1));
    tick();
    check("prime_511_state", 192'(state), 192'(1));
    check("prime_511_rd", 192'(fifo_rd), 192'(0));
    fifo_data_count = 10'd512;
    tick();
    check("run_state", 192'(state), 192'(2));
    check("run_rd", 192'(fifo_rd), 192'(1));
    fifo_data_count = 10'd100;

    // Five paced frames, 30 cycles apart
    for (int i = 1; i <= 5; i++) begin
      strobe_word(192'(i));
      check("ch0_sample", 192'(ch_data[23:0]), 192'(i));
      tick();
      check("valid_single", 192'(ch_valid), 192'(0));
      repeat (27) tick();
    end
    check("frame_cnt_5", 192'(frame_cnt), 192'(5));
    check("run_after_5", 192'(state), 192'(2));

    // Channel 7 placement
    strobe_word(ch7_word);
    check("ch7_slice", 192'(ch_data[191:168]), 192'(24'hABCDEF));
    check("ch7_rest", 192'(ch_data[167:0]), 192'(0));
    check("frame_cnt_6", 192'(frame_cnt), 192'(6));
    held = ch_data;

    // Withhold strobes: 30 quiet edges are fine, the 31st underruns
    repeat (29) tick();
    check("wd_edge_run", 192'(state), 192'(2));
    check("wd_edge_flag", 192'(underrun_flag), 192'(0));
    tick();
    check("ur_state", 192'(state), 192'(3));
    check("ur_rd", 192'(fifo_rd), 192'(0));
    check("ur_cnt", 192'(underrun_cnt), 192'(1));
    check("ur_flag", 192'(underrun_flag), 192'(1));
    check("ur_frame_cnt", 192'(frame_cnt), 192'(6));
`ifdef PLAYOUT_ZERO_ON_UNDERRUN_EN
    check("ur_data", ch_data, 192'(0));
    check("ur_valid", 192'(ch_valid), 192'(1));
`else
    check("ur_data", ch_data, held);
    check("ur_valid", 192'(ch_valid), 192'(0));
`endif
    tick();
    check("stall_hold", 192'(state), 192'(3));
    check("stall_valid", 192'(ch_valid), 192'(0));

    // Re-prime, then clear coincident with a second underrun
    fifo_data_count = 10'd512;
    tick();
    check("resume_state", 192'(state), 192'(2));
    check("resume_rd", 192'(fifo_rd), 192'(1));
    repeat (30) tick();
    check("resume_wd_run", 192'(state), 192'(2));
    clr_status = 1'b1;
    tick();
    check("ur2_state", 192'(state), 192'(3));
    check("ur2_clr_cnt", 192'(underrun_cnt), 192'(1));
    check("ur2_clr_flag", 192'(underrun_flag), 192'(1));
    // Plain clear (level still high, so RUN resumes on the same edge)
    tick();
    clr_status = 1'b0;
    check("clr_cnt", 192'(underrun_cnt), 192'(0));
    check("clr_flag", 192'(underrun_flag), 192'(0));
    check("clr_resume", 192'(state), 192'(2));

    // Disable coincident with a strobe: word still delivered
    fifo_rd_en_100ns = 1'b1; enable = 1'b0;
    tick();
    fifo_rd_en_100ns = 1'b0;
    fifo_data_out = 192'h123456;
    check("dis_state", 192'(state), 192'(0));
    check("dis_rd", 192'(fifo_rd), 192'(0));
    check("dis_valid_early", 192'(ch_valid), 192'(0));
    tick();
    check("dis_valid", 192'(ch_valid), 192'(1));
    check("dis_data", ch_data, 192'h123456);
    check("dis_frame_cnt", 192'(frame_cnt), 192'(7));
    tick();
    check("dis_valid_once", 192'(ch_valid), 192'(0));

    // Asynchronous reset while in RUN
    enable = 1'b1;
    tick();
    tick();
    check("pre_rst_state", 192'(state), 192'(2));
    check("pre_rst_rd", 192'(fifo_rd), 192'(1));
    #2;
    rstn = 1'b0;
    #1;
    check("arst_state", 192'(state), 192'(0));
    check("arst_rd", 192'(fifo_rd), 192'(0));
    check("arst_data", ch_data, 192'(0));
    check("arst_frame_cnt", 192'(frame_cnt), 192'(0));
    check("arst_ucnt", 192'(underrun_cnt), 192'(0));
    check("arst_uflag", 192'(underrun_flag), 192'(0));
    check("arst_valid", 192'(ch_valid), 192'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/frame_playout_ctrl.md
Name: frame_playout_ctrl

Overview:
- Downstream consumer of the 192-bit datapath FIFO in the Driver path.
- Decides when to start draining the FIFO: waits for a start fill level, then holds the FIFO read request high.
- Captures each word the FIFO releases on its paced read strobe and presents it as NUM_CH parallel channel samples with a one-cycle valid pulse.
- Detects missed frames (underrun), counts them, and re-primes before resuming.

Parameters:
DATA_WIDTH, 192, FIFO output word width; must equal NUM_CH*CH_WIDTH
NUM_CH, 8, number of output channels
CH_WIDTH, 24, bits per channel sample
DEPTH_SIZE, 10, width of the FIFO data_count input
START_LEVEL, 512, FIFO fill level (in output words) required to enter or resume RUN
FRAME_PERIOD, 30, nominal clk cycles between FIFO read strobes
ERR_CNT_WIDTH, 16, width of the underrun counter

Ports:
clk  in  1  clock
rstn  in  1  asynchronous reset, active-low
enable  in  1  playout enable, level
clr_status  in  1  single-cycle pulse; clears underrun_flag and underrun_cnt
fifo_data_count  in  DEPTH_SIZE  FIFO occupancy in output words
fifo_rd_en_100ns  in  1  FIFO read strobe; fifo_data_out is valid on the following cycle
fifo_data_out  in  DATA_WIDTH  FIFO registered output word
fifo_rd  out  1  read request to the FIFO
ch_data  out  DATA_WIDTH  packed channel samples; channel k = bits [k*CH_WIDTH +: CH_WIDTH]
ch_valid  out  1  one-cycle pulse when ch_data is updated
state  out  2  FSM state: 0 IDLE, 1 PRIME, 2 RUN, 3 STALL
underrun_cnt  out  ERR_CNT_WIDTH  saturating count of underrun events
underrun_flag  out  1  sticky; set on any underrun
frame_cnt  out  32  frames delivered; wraps at 2^32

Behaviour:
- Reset values: all outputs 0; state = IDLE; watchdog counter = 0; capture-pending flag = 0.
- fifo_rd is registered and equals (state == RUN).
- IDLE:
  - enable=1 -> PRIME.
- PRIME:
  - enable=0 -> IDLE.
  - fifo_data_count >= START_LEVEL -> RUN.
  - enable=0 has priority over the level check.
- RUN:
  - enable=0 -> IDLE.
  - Watchdog reaches FRAME_PERIOD -> underrun event -> STALL.
  - enable=0 has priority over the watchdog.
- STALL:
  - enable=0 -> IDLE.
  - fifo_data_count >= START_LEVEL -> RUN.
- Capture:
  - fifo_rd_en_100ns sampled high at edge N sets pending.
  - At edge N+1, ch_data <= fifo_data_out, ch_valid = 1 for exactly that cycle, frame_cnt increments.
  - Latency: strobe cycle -> ch_valid two edges later.
  - Capture happens in every state, so a strobe coincident with leaving RUN is still delivered.
  - Back-to-back strobes produce back-to-back captures.
- Watchdog (RUN only):
  - Cleared on a strobe, on entry to RUN, and outside RUN; otherwise increments each cycle.
  - Equal to FRAME_PERIOD means FRAME_PERIOD+1 cycles without a strobe -> underrun.
  - Counter width is clog2(FRAME_PERIOD+1).
- Underrun event:
  - underrun_cnt increments, saturating at all-ones.
  - underrun_flag <= 1.
  - ch_data handling depends on the optional feature.
- clr_status:
  - Clears underrun_flag and underrun_cnt next edge.
  - If an underrun event occurs in the same cycle, the event wins: flag = 1, cnt = 1.
- Reset mid-operation: everything returns to reset values immediately (async); fifo_rd drops without waiting for clk.
- Elaboration error if NUM_CH*CH_WIDTH != DATA_WIDTH.

Optional Feature:
- Macro: PLAYOUT_ZERO_ON_UNDERRUN_EN
- Defined: on an underrun event, ch_data <= 0 at the same edge the state enters STALL, and ch_valid pulses once. Downstream sees silence instead of a frozen sample. frame_cnt does not increment.
- Undefined: ch_data holds its last captured value; no ch_valid on underrun.

Test Plan:
- Reset, then enable=1, fifo_data_count=511 -> state=1, fifo_rd=0. Set count=512 -> state=2 and fifo_rd=1 one edge later.
- In RUN, strobe every 30 cycles with words 0x1..0x5 -> five ch_valid pulses, each 2 edges after its strobe; ch_data[23:0]=0x1..0x5; frame_cnt=5.
- Data word with channel 7 = 0xABCDEF and the others zero -> ch_data[191:168]=0xABCDEF, all other bits zero.
- In RUN, withhold strobes for 31 cycles -> state=3, fifo_rd=0, underrun_cnt=1, underrun_flag=1.
  - Without the macro: ch_data unchanged.
  - With PLAYOUT_ZERO_ON_UNDERRUN_EN: ch_data=0 with one ch_valid pulse.
- In STALL, raise count to 512 -> RUN. Then pulse clr_status in the same cycle as a second underrun -> underrun_flag=1, underrun_cnt=1.
- Drop enable in the same cycle as a strobe -> state=0 next edge, fifo_rd=0, and the strobed word is still captured (ch_valid pulses once). Assert rstn=0 mid-RUN -> all outputs 0 asynchronously.
